// File: rtl/program_loader_pkg.sv
// Shared types and widths for the serial program loader.
package program_loader_pkg;

    localparam int unsigned INST_W = 12;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StWrite,
        StChk,
        StDone,
        StError
    } load_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling, byte and framing-error pulses.
module program_loader_uart_rx
    import program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]        sync_q;
    logic              rx_s;
    logic              prev_q;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = RxStart;
            end
            RxStart: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[BYTE_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RxStop;
                end
            end
            RxStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/program_loader.sv
// Loads a checksummed program image received over UART into program memory.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              start,
    output logic              load_we,
    output logic [ADDR_W-1:0] load_addr,
    output logic [INST_W-1:0] load_inst,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              frame_err;

    load_state_e       state_q, state_d;
    logic [8:0]        remain_q, remain_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        hi_q, hi_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;

    program_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            remain_q <= '0;
            idx_q    <= '0;
            hi_q     <= '0;
            chk_q    <= '0;
            addr_q   <= '0;
            inst_q   <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
            hi_q     <= hi_d;
            chk_q    <= chk_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        chk_d    = chk_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StCount;
                    chk_d   = '0;
                    idx_d   = '0;
                end
            end
            StCount: begin
                if (frame_err) begin
                    state_d = StError;
                end else if (byte_valid) begin
                    // A count byte of zero stands for a full 256-instruction image.
                    remain_d = (byte_data == '0) ? 9'd256 : {1'b0, byte_data};
                    chk_d    = chk_q ^ byte_data;
                    state_d  = StHi;
                end
            end
            StHi: begin
                if (frame_err) begin
                    state_d = StError;
                end else if (byte_valid) begin
                    hi_d    = byte_data[3:0];
                    chk_d   = chk_q ^ byte_data;
                    state_d = StLo;
                end
            end
            StLo: begin
                if (frame_err) begin
                    state_d = StError;
                end else if (byte_valid) begin
                    chk_d   = chk_q ^ byte_data;
                    addr_d  = idx_q;
                    inst_d  = {hi_q, byte_data};
                    state_d = StWrite;
                end
            end
            StWrite: begin
                idx_d    = idx_q + ADDR_W'(1);
                remain_d = remain_q - 9'd1;
                state_d  = (remain_q == 9'd1) ? StChk : StHi;
            end
            StChk: begin
                if (frame_err) begin
                    state_d = StError;
                end else if (byte_valid) begin
                    state_d = (byte_data == chk_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign load_we   = (state_q == StWrite);
    assign load_addr = addr_q;
    assign load_inst = inst_q;
    assign load_done = (state_q == StDone);
    assign load_err  = (state_q == StError);
    assign busy      = !(state_q inside {StIdle, StDone, StError});

endmodule
